rd_burst_arb: RTL and testbench

RD_BURST_ARB -- requirements
Module: rd_burst_arb

---
 rtl/rd_burst_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/rd_burst_arb.sv | 169 ++++++++++++++++
 tb/tb_rd_burst_arb.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_burst_arb_pkg.sv
// Shared types and helpers for the read-burst arbiter.
// Holds the FSM state encoding and the burst-length decode rule
// (a programmed length of 0 still moves one beat).
package rd_burst_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A zero length field means a single-beat burst; any other value is taken as is.
  function automatic int unsigned eff_burst_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker.
// Scans the request vector starting at the priority pointer and wraps
// around, returning a one-hot grant (all zeros when nothing is requesting).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // First requester at or after ptr (modulo NUM_REQ) wins.
  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rd_burst_arb.sv
// Read-burst arbiter sitting on the read side of a FIFO.
// Grants one requester at a time (round-robin), then streams its burst of
// FIFO words out on o_data/o_valid, pausing whenever the FIFO is empty.
// Each burst ends with a one-cycle o_done pulse to its owner.
// Optional feature: define RD_BURST_ARB_TIMEOUT_EN to abandon a burst that
// has stalled on an empty FIFO for TIMEOUT_CYC consecutive cycles; the burst
// then ends with an o_abort pulse instead of o_done. Without the macro the
// burst waits indefinitely and o_abort stays 0.
module rd_burst_arb
  import rd_burst_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BLEN_W      = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      i_rd_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*BLEN_W-1:0] i_burst_len,
  input  logic                      i_empty_flag,
  input  logic [DATA_WIDTH-1:0]     i_rd_data,
  output logic                      o_rd_en,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_valid,
  output logic [NUM_REQ-1:0]        o_done,
  output logic                      o_abort
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || BLEN_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("rd_burst_arb: parameter out of range");
  end

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   next_ptr;
  logic [BLEN_W-1:0]  len_q;
  logic [BLEN_W-1:0]  beat_cnt;
  logic [BLEN_W-1:0]  beat_next;
  logic               last_beat;
  logic [NUM_REQ-1:0] rr_grant;
  logic [PTR_W-1:0]   rr_idx;
  logic [BLEN_W-1:0]  sel_len;
  logic [BLEN_W-1:0]  dec_len;

`ifdef RD_BURST_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               abort_q;

  assign o_abort = abort_q;
`else
  assign o_abort = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (i_req),
    .ptr   (ptr),
    .grant (rr_grant)
  );

  // Turn the one-hot arbiter result into an index and pick that requester's length field.
  always_comb begin
    rr_idx  = '0;
    sel_len = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rr_grant[k]) begin
        rr_idx  = PTR_W'(k);
        sel_len = i_burst_len[k*BLEN_W +: BLEN_W];
      end
    end
  end

  assign dec_len   = BLEN_W'(eff_burst_len(32'(sel_len)));
  assign beat_next = beat_cnt + BLEN_W'(1);
  assign last_beat = (beat_next == len_q);
  assign next_ptr  = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

  // The FIFO is popped combinationally so the word on i_rd_data is consumed this cycle.
  assign o_rd_en = (state == BURST) && !i_empty_flag;

  // Burst FSM with registered grant, data, valid and completion outputs.
  always_ff @(posedge i_rd_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the data register is cleared too so o_data reads 0 after reset,
      // not whatever the last burst left behind.
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      o_grant  <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_done   <= '0;
`ifdef RD_BURST_ARB_TIMEOUT_EN
      stall_cnt <= '0;
      abort_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees the
      // pre-edge value of every other register regardless of statement order.
      o_valid <= o_rd_en;
      o_done  <= '0;
`ifdef RD_BURST_ARB_TIMEOUT_EN
      abort_q <= 1'b0;
`endif
      if (o_rd_en) begin
        o_data <= i_rd_data;
      end

      case (state)
        IDLE: begin
          if (|i_req) begin
            o_grant  <= rr_grant;
            owner    <= rr_idx;
            len_q    <= dec_len;
            beat_cnt <= '0;
`ifdef RD_BURST_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            state    <= BURST;
          end
        end

        BURST: begin
          if (o_rd_en) begin
            beat_cnt <= beat_next;
`ifdef RD_BURST_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (last_beat) begin
              o_done <= o_grant;
              state  <= DONE;
            end
          end
`ifdef RD_BURST_ARB_TIMEOUT_EN
          else if (stall_cnt == STALL_LAST) begin
            abort_q <= 1'b1;
            state   <= DONE;
          end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
`endif
        end

        DONE: begin
          ptr     <= next_ptr;
          o_grant <= '0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_burst_arb.sv
// Self-checking bench for rd_burst_arb.
// A bench-side FIFO supplies i_rd_data and advances on o_rd_en. Each issued
// burst is predicted by a round-robin model (owner, beat count, FIFO words)
// and pushed onto scoreboard queues; a negedge monitor pops and compares
// every o_valid beat and every o_done/o_abort pulse.
module tb_rd_burst_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int TO = 16;

  typedef struct {
    logic [N-1:0] vec;
    int           beats;
    bit           abort;
  } end_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    i_req = '0;
  logic [N*BW-1:0] i_burst_len = '0;
  logic            i_empty_flag;
  logic [DW-1:0]   i_rd_data;
  logic            o_rd_en;
  logic [N-1:0]    o_grant;
  logic [DW-1:0]   o_data;
  logic            o_valid;
  logic [N-1:0]    o_done;
  logic            o_abort;

  logic            empty_force = 1'b1;
  logic            empty_val   = 1'b0;
  logic            empty_rand  = 1'b0;

  logic [DW-1:0]   fifo_mem [256];
  logic [7:0]      fifo_rd = '0;
  int              cyc = 0;

  logic [DW-1:0]   exp_data [$];
  end_t            exp_end  [$];
  int              model_ptr = 0;
  int              model_rd  = 0;

  int              checks = 0;
  int              errors = 0;

  rd_burst_arb #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (DW),
    .BLEN_W      (BW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_rd_clk     (clk),
    .i_rst        (rst),
    .i_req        (i_req),
    .i_burst_len  (i_burst_len),
    .i_empty_flag (i_empty_flag),
    .i_rd_data    (i_rd_data),
    .o_rd_en      (o_rd_en),
    .o_grant      (o_grant),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_done       (o_done),
    .o_abort      (o_abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) empty_rand <= ($urandom_range(0, 3) == 0);
  always @(posedge clk) if (o_rd_en) fifo_rd <= fifo_rd + 8'd1;

  assign i_empty_flag = empty_force ? empty_val : empty_rand;
  assign i_rd_data    = fifo_mem[fifo_rd];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*BW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {BW'(l3), BW'(l2), BW'(l1), BW'(l0)};
  endfunction

  // Reference model: pick the owner round-robin from model_ptr, work out how
  // many FIFO words the burst moves, and queue the expected results.
  task automatic model_issue(input logic [N-1:0] mask, input logic [N*BW-1:0] lens, input int cut);
    int          owner;
    int          j;
    int          len;
    logic [BW-1:0] f;
    end_t        e;
    owner = -1;
    for (int k = 0; k < N; k++) begin
      j = (model_ptr + k) % N;
      if (owner < 0 && mask[j]) owner = j;
    end
    f   = lens[owner*BW +: BW];
    len = (f == 0) ? 1 : int'(f);
    if (cut >= 0) len = cut;
    for (int b = 0; b < len; b++) exp_data.push_back(fifo_mem[8'(model_rd + b)]);
    model_rd  = (model_rd + len) % 256;
    e.vec     = N'(1) << owner;
    e.beats   = len;
    e.abort   = (cut >= 0);
    exp_end.push_back(e);
    model_ptr = (owner + 1) % N;
  endtask

  task automatic start(input logic [N-1:0] mask, input logic [N*BW-1:0] lens, input int cut);
    model_issue(mask, lens, cut);
    i_req       = mask;
    i_burst_len = lens;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    bit seen;
    seen = 1'b0;
    g    = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (o_grant != '0) begin
        g    = o_grant;
        seen = 1'b1;
      end
    end
    check("grant_seen", 32'(seen), 1);
  endtask

  task automatic wait_end(output int c);
    bit seen;
    seen = 1'b0;
    c    = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge clk); #1;
      if (o_done != '0 || o_abort) begin
        c    = cyc;
        seen = 1'b1;
      end
    end
    check("end_seen", 32'(seen), 1);
  endtask

  // Monitor: scoreboard every output beat and every burst completion.
  initial begin
    int   beats;
    int   rd_cnt;
    end_t e;
    beats  = 0;
    rd_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        beats  = 0;
        rd_cnt = 0;
      end else begin
        if (i_empty_flag) check("rd_en_while_empty", 32'(o_rd_en), 0);
        if (o_rd_en) begin
          rd_cnt++;
          check("rd_en_owner_known", 32'(exp_end.size() > 0), 1);
          if (exp_end.size() > 0) check("rd_en_grant", 32'(o_grant), 32'(exp_end[0].vec));
        end
        if (o_valid) begin
          beats++;
          check("data_expected", 32'(exp_data.size() > 0), 1);
          if (exp_data.size() > 0) check("data", 32'(o_data), 32'(exp_data.pop_front()));
        end
        if (o_done != '0 || o_abort) begin
          check("end_expected", 32'(exp_end.size() > 0), 1);
          if (exp_end.size() > 0) begin
            e = exp_end.pop_front();
            check("done_vec", 32'(o_done), e.abort ? 32'd0 : 32'(e.vec));
            check("abort", 32'(o_abort), 32'(e.abort));
            check("beats_valid", beats, e.beats);
            check("beats_rd_en", rd_cnt, e.beats);
          end
          beats  = 0;
          rd_cnt = 0;
        end
      end
    end
  end

  initial begin
    logic [N-1:0]    g;
    logic [N*BW-1:0] lens;
    int              c;
    int              prev;
    int              s;
    int              order [5];

    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 256; i++) fifo_mem[i] = DW'($urandom);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(o_grant), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_done",  32'(o_done),  0);
    check("rst_rd_en", 32'(o_rd_en), 0);
    check("rst_data",  32'(o_data),  0);
    check("rst_abort", 32'(o_abort), 0);
    rst = 1'b0;

    // Single requester, len 3, FIFO never empty: first read one cycle after request.
    @(posedge clk); #1;
    start(4'b0001, pack4(3, 0, 0, 0), -1);
    @(negedge clk);
    check("lat_idle_no_rd", 32'(o_rd_en), 0);
    @(negedge clk);
    check("lat_first_rd", 32'(o_rd_en), 1);
    wait_end(c);
    i_req = '0;

    // Zero length moves exactly one beat.
    start(4'b0010, pack4(0, 0, 0, 0), -1);
    wait_grant(g);
    check("zero_len_grant", 32'(g), 32'(4'b0010));
    wait_end(c);
    i_req = '0;

    // Empty stall of 5 cycles after beat 2 of a 4-beat burst.
    start(4'b0100, pack4(0, 0, 4, 0), -1);
    wait_grant(g);
    check("stall_grant", 32'(g), 32'(4'b0100));
    @(posedge clk); #1;
    @(posedge clk); #1;
    empty_val = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    empty_val = 1'b0;
    wait_end(c);
    i_req = '0;

    // Owner drops its request after beat 1; burst still completes.
    start(4'b1000, pack4(0, 0, 0, 3), -1);
    wait_grant(g);
    check("drop_grant", 32'(g), 32'(4'b1000));
    @(posedge clk); #1;
    i_req = '0;
    wait_end(c);

    // Long empty stall mid-burst, then the next requester must be served.
    lens = pack4(8, 8, 0, 0);
`ifdef RD_BURST_ARB_TIMEOUT_EN
    start(4'b0011, lens, 2);
`else
    start(4'b0011, lens, -1);
`endif
    wait_grant(g);
    check("stall_long_grant", 32'(g), 32'(4'b0001));
    @(posedge clk); #1;
    @(posedge clk); #1;
    empty_val = 1'b1;
    s = cyc;
`ifdef RD_BURST_ARB_TIMEOUT_EN
    wait_end(c);
    check("abort_delay", c - s, TO);
    empty_val = 1'b0;
`else
    repeat (20) @(posedge clk);
    #1;
    check("no_timeout_grant_held", 32'(o_grant), 32'(4'b0001));
    check("no_timeout_no_abort", 32'(o_abort), 0);
    empty_val = 1'b0;
    wait_end(c);
`endif
    start(4'b0011, lens, -1);
    wait_grant(g);
    check("next_after_stall", 32'(g), 32'(4'b0010));
    wait_end(c);
    i_req = '0;

    // Reset pulse in the middle of a burst clears every output at once.
    @(posedge clk); #1;
    start(4'b0100, pack4(0, 0, 8, 0), -1);
    wait_grant(g);
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_grant", 32'(o_grant), 0);
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_done",  32'(o_done),  0);
    check("midrst_rd_en", 32'(o_rd_en), 0);
    check("midrst_data",  32'(o_data),  0);
    check("midrst_abort", 32'(o_abort), 0);
    exp_data.delete();
    exp_end.delete();
    model_ptr = 0;
    i_req     = '0;
    @(posedge clk); #1;
    rst      = 1'b0;
    model_rd = int'(fifo_rd);

    // Fairness: all requesting, len 1 each -> 0,1,2,3,0 every 3 cycles.
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      start(4'b1111, pack4(1, 1, 1, 1), -1);
      wait_grant(g);
      check($sformatf("fair_grant_%0d", i), 32'(g), 32'(N'(1) << order[i]));
      wait_end(c);
      if (i > 0) check($sformatf("fair_period_%0d", i), c - prev, 3);
      prev = c;
    end
    i_req = '0;

    // Randomised traffic with random FIFO empties and mid-burst request churn.
    empty_force = 1'b0;
    for (int t = 0; t < 60; t++) begin
      start(N'($urandom_range(1, (1 << N) - 1)), (N*BW)'($urandom), -1);
      wait_grant(g);
      if ($urandom_range(0, 1) == 1) begin
        i_req       = N'($urandom);
        i_burst_len = (N*BW)'($urandom);
      end
      wait_end(c);
    end
    i_req       = '0;
    empty_force = 1'b1;
    empty_val   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("data_left", exp_data.size(), 0);
    check("end_left",  exp_end.size(),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
